fc_dot_sequencer: RTL and testbench
===================================

# fc_dot_sequencer

Control stage directly upstream of the fully-connected layer's multiply-accumulate unit. On a start pulse it walks an input vector and a weight row held in synchronous-read memories and drives the MAC operand, enable and accumulator-feedback ports at one term per cycle. It captures the finished dot product and presents it on a valid/ready output to the downstream activation stage.

## Interface
- DATA_WIDTH, 16, operand width; must match the MAC's operand width.
- ACC_WIDTH, 32, accumulator width; must match the MAC's accumulator width.
- VEC_LEN, 64, maximum number of terms per dot product.
- ADDR_WIDTH, $clog2(VEC_LEN), memory address width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- len  in  ADDR_WIDTH+1  number of terms; sampled with start.
- bias  in  ACC_WIDTH signed  initial accumulator value; sampled with start.
- x_addr  out  ADDR_WIDTH  input-vector read address.
- w_addr  out  ADDR_WIDTH  weight-row read address.
- x_data  in  DATA_WIDTH signed  input-vector read data, one cycle after x_addr.
- w_data  in  DATA_WIDTH signed  weight read data, one cycle after w_addr.
- mac_en  out  1  MAC enable.
- mac_a  out  DATA_WIDTH signed  MAC operand A (x_data).
- mac_b  out  DATA_WIDTH signed  MAC operand B (w_data).
- mac_acc_in  out  ACC_WIDTH signed  MAC accumulator input.
- mac_acc_out  in  ACC_WIDTH signed  registered MAC accumulator output.
- busy  out  1  high in every state except IDLE.
- result  out  ACC_WIDTH signed  captured dot product.
- result_valid  out  1  result is available.
- result_ready  in  1  downstream accepts result.

## Operation
- States:
  - IDLE: waits for start.
  - RUN: issues addresses 0..n-1, one per cycle.
  - TAIL: the final MAC term is enabled.
  - CAPTURE: result <= mac_acc_out.
  - OUT: result_valid is held high.
- n = min(len, VEC_LEN). If len > VEC_LEN, the block clamps n to VEC_LEN.
- x_addr and w_addr are equal: one shared address counter. Addresses hold at 0 outside RUN.
- mac_en is the issue strobe delayed by one cycle. mac_a and mac_b pass x_data and w_data through combinationally. mac_a and mac_b are 0 when mac_en is low.
- mac_acc_in is the bias register on the first enabled term and mac_acc_out on every later term.
- The MAC truncates the product and wraps on overflow; this block adds no saturation.
- n = 0: IDLE goes to CAPTURE with no mac_en pulse, and result = bias.
- OUT exits to IDLE on the cycle where result_valid and result_ready are both high. A start in that same cycle is ignored; the block is ready again on the next cycle.
- start while busy is ignored, and len and bias are not resampled.
- Reset mid-operation aborts immediately. All outputs go to their reset values and the partial sum is discarded.

## Timing
- Reset values:
  - state = IDLE.
  - x_addr = w_addr = 0.
  - mac_en = 0; mac_a = mac_b = 0; mac_acc_in = 0.
  - busy = 0.
  - result = 0; result_valid = 0.
- Cycle numbering: start is high in cycle 0.
  - RUN occupies cycles 1..n.
  - mac_en is high in cycles 2..n+1, with TAIL at cycle n+1.
  - CAPTURE occupies cycle n+2.
  - result_valid rises in cycle n+3.
- Latency from start to result_valid is n+3 cycles (3 cycles when n = 0). Throughput is one term per cycle.
- result and result_valid are registered. Both hold stable while result_ready is low.
- busy is registered and rises in cycle 1.

## Configuration
- FC_SEQ_BIAS_EN defined: the first term uses the sampled bias as mac_acc_in, and n = 0 yields result = bias.
- FC_SEQ_BIAS_EN undefined: the bias port is ignored and no bias register is built. The first term uses mac_acc_in = 0, and n = 0 yields result = 0.

## Test plan
- len=4, x={1,2,3,4}, w={5,6,7,8}, bias=10, result_ready=1 -> mac_en high in cycles 2..5, result=80, result_valid high for exactly one cycle at cycle 7.
- len=1, x={-3}, w={100}, bias=-1 -> result=-301. Repeat with FC_SEQ_BIAS_EN undefined -> result=-300.
- len=0, bias=42 -> mac_en never asserted, result=42 valid at cycle 3. With FC_SEQ_BIAS_EN undefined -> result=0.
- len=4 as above with result_ready held low for 5 cycles -> result stays 80 with valid high throughout. A start pulse during OUT is ignored. The block returns to IDLE the cycle after ready rises.
- len=100 with VEC_LEN=64 -> addresses 0..63 only, 64 mac_en cycles, result_valid at cycle 67.
- rst asserted during cycle 3 of a len=8 run -> mac_en, busy and result_valid drop immediately. After release, a fresh len=2 run (x={2,3}, w={4,5}, bias=0) yields result=23.

Source files
------------

// File: rtl/fc_dot_sequencer.sv
// rtl/fc_dot_sequencer.sv - dot-product sequencer driving the FC-layer MAC; FC_SEQ_BIAS_EN enables the bias register
module fc_dot_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int VEC_LEN    = 64,
    parameter int ADDR_WIDTH = $clog2(VEC_LEN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_WIDTH:0]          len,
    input  logic signed [ACC_WIDTH-1:0]  bias,
    output logic [ADDR_WIDTH-1:0]        x_addr,
    output logic [ADDR_WIDTH-1:0]        w_addr,
    input  logic signed [DATA_WIDTH-1:0] x_data,
    input  logic signed [DATA_WIDTH-1:0] w_data,
    output logic                         mac_en,
    output logic signed [DATA_WIDTH-1:0] mac_a,
    output logic signed [DATA_WIDTH-1:0] mac_b,
    output logic signed [ACC_WIDTH-1:0]  mac_acc_in,
    input  logic signed [ACC_WIDTH-1:0]  mac_acc_out,
    output logic                         busy,
    output logic signed [ACC_WIDTH-1:0]  result,
    output logic                         result_valid,
    input  logic                         result_ready
);

    typedef enum logic [2:0] {IDLE, RUN, TAIL, CAPTURE, OUT} state_t;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(VEC_LEN);

    state_t                       state;
    logic [ADDR_WIDTH-1:0]        addr;
    logic [ADDR_WIDTH-1:0]        last;
    logic                         first;
    logic                         empty;
    logic                         hold;
    logic [ADDR_WIDTH:0]          n;
    logic signed [ACC_WIDTH-1:0]  bias_val;

    assign n = (len > MAX_LEN) ? MAX_LEN : len;

`ifdef FC_SEQ_BIAS_EN
    logic signed [ACC_WIDTH-1:0] bias_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bias_q <= '0;
        end else if (state == IDLE && start) begin
            bias_q <= bias;
        end
    end

    assign bias_val = bias_q;
`else
    logic unused_bias;

    assign unused_bias = ^bias;
    assign bias_val    = '0;
`endif

    assign x_addr     = addr;
    assign w_addr     = addr;
    assign mac_a      = mac_en ? x_data : '0;
    assign mac_b      = mac_en ? w_data : '0;
    assign mac_acc_in = !mac_en ? '0 : (first ? bias_val : mac_acc_out);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            addr         <= '0;
            last         <= '0;
            first        <= 1'b0;
            empty        <= 1'b0;
            hold         <= 1'b0;
            mac_en       <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            // Read data lags the address by one cycle, so the MAC strobe trails the issue strobe.
            mac_en <= (state == RUN);
            if (mac_en) begin
                first <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        first <= 1'b1;
                        addr  <= '0;
                        last  <= ADDR_WIDTH'(n - 1);
                        empty <= (n == '0);
                        hold  <= (n == '0);
                        state <= (n == '0) ? CAPTURE : RUN;
                    end
                end
                RUN: begin
                    if (addr == last) begin
                        addr  <= '0;
                        state <= TAIL;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                TAIL: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    // An empty vector spends one extra cycle here to keep latency at n+3.
                    if (hold) begin
                        hold <= 1'b0;
                    end else begin
                        result       <= empty ? bias_val : mac_acc_out;
                        result_valid <= 1'b1;
                        state        <= OUT;
                    end
                end
                OUT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_dot_sequencer.sv
// tb/tb_fc_dot_sequencer.sv - self-checking bench for fc_dot_sequencer with memory and MAC models
`timescale 1ns/1ps
module tb_fc_dot_sequencer;

    localparam int DW = 16;
    localparam int CW = 32;
    localparam int VL = 64;
    localparam int AW = 6;

`ifdef FC_SEQ_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic [AW:0]          len = '0;
    logic signed [CW-1:0] bias = '0;
    logic [AW-1:0]        x_addr, w_addr;
    logic signed [DW-1:0] x_data = '0;
    logic signed [DW-1:0] w_data = '0;
    logic                 mac_en;
    logic signed [DW-1:0] mac_a, mac_b;
    logic signed [CW-1:0] mac_acc_in;
    logic signed [CW-1:0] mac_acc_out = '0;
    logic                 busy;
    logic signed [CW-1:0] result;
    logic                 result_valid;
    logic                 result_ready = 1'b1;

    logic signed [DW-1:0] x_mem [VL];
    logic signed [DW-1:0] w_mem [VL];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fc_dot_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(CW), .VEC_LEN(VL), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias),
        .x_addr(x_addr), .w_addr(w_addr), .x_data(x_data), .w_data(w_data),
        .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
        .mac_acc_in(mac_acc_in), .mac_acc_out(mac_acc_out),
        .busy(busy), .result(result), .result_valid(result_valid),
        .result_ready(result_ready)
    );

    always @(posedge clk) begin
        x_data <= x_mem[x_addr];
        w_data <= w_mem[w_addr];
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) mac_acc_out <= '0;
        else if (mac_en) mac_acc_out <= mac_acc_in + mac_a * mac_b;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dot(input int k, input int b);
        int acc;
        acc = b;
        for (int i = 0; i < k; i++) acc += int'(x_mem[i]) * int'(w_mem[i]);
        return acc;
    endfunction

    // Reference model: m_t counts cycles since the accepted start (cycle 1 = first busy cycle).
    bit m_active = 1'b0;
    int m_t = 0;
    int m_n = 0;
    int m_bias = 0;
    int m_result = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 1'b0;
            m_t      = 0;
            m_result = 0;
        end else if (m_active) begin
            if (m_t == m_n + 2) m_result = dot(m_n, m_bias);
            if (m_t >= m_n + 3 && result_ready) m_active = 1'b0;
            else m_t++;
        end else if (start) begin
            m_active = 1'b1;
            m_t      = 1;
            m_n      = (int'(len) > VL) ? VL : int'(len);
            m_bias   = BIAS_EN ? int'(bias) : 0;
        end
    end

    always @(negedge clk) begin
        bit een;
        int ea, xa, wb, acc;
        een = m_active && m_t >= 2 && m_t <= m_n + 1;
        ea  = (m_active && m_t <= m_n) ? m_t - 1 : 0;
        xa  = 0;
        wb  = 0;
        acc = 0;
        if (een) begin
            xa  = int'(x_mem[m_t - 2]);
            wb  = int'(w_mem[m_t - 2]);
            acc = dot(m_t - 2, m_bias);
        end
        check("x_addr", int'(x_addr), ea);
        check("w_addr", int'(w_addr), ea);
        check("mac_en", int'(mac_en), int'(een));
        check("mac_a", int'(mac_a), xa);
        check("mac_b", int'(mac_b), wb);
        check("mac_acc_in", int'(mac_acc_in), acc);
        check("busy", int'(busy), int'(m_active));
        check("result_valid", int'(result_valid), int'(m_active && m_t >= m_n + 3));
        check("result", int'(result), m_result);
    end

    task automatic load(input int i, input int xv, input int wv);
        x_mem[i] = xv[DW-1:0];
        w_mem[i] = wv[DW-1:0];
    endtask

    task automatic do_start(input int l, input int b);
        @(posedge clk); #1;
        start = 1'b1;
        len   = l[AW:0];
        bias  = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int cyc, output int en_cnt, output int max_addr);
        cyc = 1;
        en_cnt = 0;
        max_addr = 0;
        while (!result_valid && cyc < limit) begin
            if (mac_en) en_cnt++;
            if (int'(x_addr) > max_addr) max_addr = int'(x_addr);
            @(posedge clk); #1;
            cyc++;
        end
        if (!result_valid) check("valid_timeout", 0, 1);
    endtask

    initial begin
        int lat, en_cnt, max_addr;
        for (int i = 0; i < VL; i++) load(i, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(result_valid), 0);
        check("rst_mac_en", int'(mac_en), 0);
        check("rst_addr", int'(x_addr), 0);
        check("rst_result", int'(result), 0);
        check("rst_acc_in", int'(mac_acc_in), 0);
        rst = 1'b1;

        // len=4 basic run
        load(0, 1, 5); load(1, 2, 6); load(2, 3, 7); load(3, 4, 8);
        do_start(4, 10);
        wait_valid(200, lat, en_cnt, max_addr);
        check("t1_latency", lat, 7);
        check("t1_en_cycles", en_cnt, 4);
        check("t1_result", int'(result), BIAS_EN ? 80 : 70);
        @(posedge clk); #1;
        check("t1_valid_one_cycle", int'(result_valid), 0);

        // len=1 negative operand
        load(0, -3, 100);
        do_start(1, -1);
        wait_valid(200, lat, en_cnt, max_addr);
        check("t2_latency", lat, 4);
        check("t2_result", int'(result), BIAS_EN ? -301 : -300);

        // len=0
        do_start(0, 42);
        wait_valid(200, lat, en_cnt, max_addr);
        check("t3_latency", lat, 3);
        check("t3_en_cycles", en_cnt, 0);
        check("t3_result", int'(result), BIAS_EN ? 42 : 0);

        // backpressure with a stray start during OUT
        load(0, 1, 5); load(1, 2, 6); load(2, 3, 7); load(3, 4, 8);
        @(posedge clk); #1;
        result_ready = 1'b0;
        do_start(4, 10);
        wait_valid(200, lat, en_cnt, max_addr);
        check("t4_latency", lat, 7);
        for (int j = 0; j < 5; j++) begin
            start = (j == 2);
            len   = 7'd1;
            check("t4_hold_valid", int'(result_valid), 1);
            check("t4_hold_result", int'(result), BIAS_EN ? 80 : 70);
            @(posedge clk); #1;
        end
        start = 1'b0;
        result_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_idle_busy", int'(busy), 0);
        check("t4_idle_valid", int'(result_valid), 0);

        // len clamp
        for (int i = 0; i < VL; i++) load(i, i + 1, 2);
        do_start(100, 0);
        wait_valid(300, lat, en_cnt, max_addr);
        check("t5_latency", lat, 67);
        check("t5_en_cycles", en_cnt, 64);
        check("t5_max_addr", max_addr, 63);
        check("t5_result", int'(result), 4160);

        // reset during a run, then a fresh run
        do_start(8, 5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t6_pre_mac_en", int'(mac_en), 1);
        rst = 1'b0;
        #1;
        check("t6_rst_mac_en", int'(mac_en), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_valid", int'(result_valid), 0);
        check("t6_rst_result", int'(result), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        load(0, 2, 4); load(1, 3, 5);
        do_start(2, 0);
        wait_valid(200, lat, en_cnt, max_addr);
        check("t6_latency", lat, 5);
        check("t6_result", int'(result), 23);
        repeat (2) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
